// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: turns three 8-bit colour intensities into three PWM pins.
// Duties are captured into pending registers on update and copied into the
// active registers only at a period wrap (or continuously while idle), so a
// running period is never torn by a mid-period change.
module rgb_pwm_driver #(
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       update,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       period_start
);

  localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [7:0]       CNT_MAX = 8'd254;

  logic             run;
  logic [PRE_W-1:0] pre;
  logic [7:0]       cnt;
  logic [7:0]       pend_r, pend_g, pend_b;
  logic [7:0]       act_r, act_g, act_b;
  logic             tick;
  logic             wrap;

  // Pin level for one channel: active while the counter is below the duty.
  // cnt never exceeds 254, so duty 255 stays active for the whole period.
  function automatic logic pwm_level(input logic running, input logic [7:0] count,
                                     input logic [7:0] duty);
    return ACTIVE_LOW ^ (running && (count < duty));
  endfunction

  assign tick = run && (pre == PRE_MAX);
  assign wrap = tick && (cnt == CNT_MAX);

  // Registered-only decode: no input reaches period_start combinationally.
  assign period_start = run && (cnt == 8'd0) && (pre == '0);

  // Run request register.
  always_ff @(posedge clk) begin
    if (rst) run <= 1'b0;
    else     run <= en;
  end

  // Prescaler and period counter; both held at zero while idle so that a
  // disable aborts the partial period and a re-enable starts a fresh one.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= wrap ? 8'd0 : cnt + 8'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Pending duty capture, accepted in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= '0;
      pend_g <= '0;
      pend_b <= '0;
    end else if (update) begin
      pend_r <= r_in;
      pend_g <= g_in;
      pend_b <= b_in;
    end
  end

  // Active duty: follows pending while idle, otherwise only at the wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_r <= '0;
      act_g <= '0;
      act_b <= '0;
    end else if (!run || wrap) begin
      act_r <= pend_r;
      act_g <= pend_g;
      act_b <= pend_b;
    end
  end

  // Output flops: one clk behind the (cnt, act) state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= ACTIVE_LOW;
      pwm_g <= ACTIVE_LOW;
      pwm_b <= ACTIVE_LOW;
    end else begin
      pwm_r <= pwm_level(run, cnt, act_r);
      pwm_g <= pwm_level(run, cnt, act_g);
      pwm_b <= pwm_level(run, cnt, act_b);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance with PRESCALE=1 and
// active-high pins, one with PRESCALE=3 and active-low pins.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: PRESCALE=1, ACTIVE_LOW=0
  logic       rst, en, update;
  logic [7:0] r_in, g_in, b_in;
  logic       pwm_r, pwm_g, pwm_b, period_start;

  // Instance B: PRESCALE=3, ACTIVE_LOW=1
  logic       rst2, en2, update2;
  logic [7:0] r_in2, g_in2, b_in2;
  logic       pwm_r2, pwm_g2, pwm_b2, period_start2;

  int n_cmp = 0;
  int n_err = 0;

  rgb_pwm_driver #(.PRESCALE(1), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .update(update),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .period_start(period_start)
  );

  rgb_pwm_driver #(.PRESCALE(3), .ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst(rst2), .en(en2), .update(update2),
    .r_in(r_in2), .g_in(g_in2), .b_in(b_in2),
    .pwm_r(pwm_r2), .pwm_g(pwm_g2), .pwm_b(pwm_b2),
    .period_start(period_start2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles on instance A, counting high cycles of each pin and of
  // period_start. If upd_at >= 0, update is pulsed on that step's edge.
  task automatic run_cycles(input int n, input int upd_at,
                            input logic [7:0] ur, input logic [7:0] ug,
                            input logic [7:0] ub,
                            output int hr, output int hg, output int hb,
                            output int hps);
    hr = 0; hg = 0; hb = 0; hps = 0;
    for (int i = 0; i < n; i++) begin
      if (i == upd_at) begin
        update = 1'b1; r_in = ur; g_in = ug; b_in = ub;
      end else begin
        update = 1'b0;
      end
      step();
      hr  += int'(pwm_r);
      hg  += int'(pwm_g);
      hb  += int'(pwm_b);
      hps += int'(period_start);
    end
    update = 1'b0;
  endtask

  int hr, hg, hb, hps;
  int lr, lg, lb, lps;

  initial begin
    rst = 1'b1; en = 1'b0; update = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    rst2 = 1'b1; en2 = 1'b0; update2 = 1'b0; r_in2 = '0; g_in2 = '0; b_in2 = '0;
    step();
    step();

    // Reset defaults
    chk("rst_pwm_r", pwm_r, 0);
    chk("rst_pwm_g", pwm_g, 0);
    chk("rst_pwm_b", pwm_b, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_inv_pwm_r", pwm_r2, 1);
    chk("rst_inv_pwm_g", pwm_g2, 1);
    chk("rst_inv_pwm_b", pwm_b2, 1);
    chk("rst_inv_ps", period_start2, 0);
    rst = 1'b0; rst2 = 1'b0;

    // Basic duty: R=0, G=128, B=255
    update = 1'b1; r_in = 8'd0; g_in = 8'd128; b_in = 8'd255;
    step();
    update = 1'b0;
    chk("idle_ps", period_start, 0);
    chk("idle_pwm_b", pwm_b, 0);
    en = 1'b1;
    step();
    chk("en_ps", period_start, 1);
    chk("en_pwm_b_first", pwm_b, 0);
    run_cycles(255, -1, 0, 0, 0, hr, hg, hb, hps);
    chk("basic_r", hr, 0);
    chk("basic_g", hg, 128);
    chk("basic_b", hb, 255);
    chk("basic_ps_cnt", hps, 1);
    chk("basic_ps_end", period_start, 1);
    // Update to G=100 at the start of this period; it applies next period.
    run_cycles(255, 0, 8'd0, 8'd100, 8'd255, hr, hg, hb, hps);
    chk("basic2_g", hg, 128);
    chk("basic2_ps_cnt", hps, 1);

    // Mid-period update: G=100 active, update to G=20 at cnt=50
    run_cycles(255, 50, 8'd0, 8'd20, 8'd255, hr, hg, hb, hps);
    chk("mid_cur_g", hg, 100);
    chk("mid_cur_ps", period_start, 1);
    run_cycles(255, -1, 0, 0, 0, hr, hg, hb, hps);
    chk("mid_next_g", hg, 20);
    chk("mid_next_b", hb, 255);

    // Update on the wrap edge: G=10 lands on the edge where cnt goes 254->0
    run_cycles(255, 254, 8'd0, 8'd10, 8'd255, hr, hg, hb, hps);
    chk("wrap_cur_g", hg, 20);
    run_cycles(255, -1, 0, 0, 0, hr, hg, hb, hps);
    chk("wrap_next_g", hg, 20);
    run_cycles(255, -1, 0, 0, 0, hr, hg, hb, hps);
    chk("wrap_after_g", hg, 10);
    chk("wrap_after_ps", hps, 1);

    // Enable toggle: drop en at cnt=30
    run_cycles(30, -1, 0, 0, 0, hr, hg, hb, hps);
    en = 1'b0;
    step();
    chk("dis_k_pwm_b", pwm_b, 1);
    chk("dis_k_ps", period_start, 0);
    step();
    chk("dis_k1_pwm_b", pwm_b, 0);
    chk("dis_k1_ps", period_start, 0);
    run_cycles(10, 2, 8'd200, 8'd0, 8'd0, hr, hg, hb, hps);
    chk("idle_ps_cnt", hps, 0);
    chk("idle_pins", hr + hg + hb, 0);
    en = 1'b1;
    step();
    chk("reen_ps", period_start, 1);
    run_cycles(255, -1, 0, 0, 0, hr, hg, hb, hps);
    chk("reen_r", hr, 200);
    chk("reen_g", hg, 0);
    chk("reen_ps_cnt", hps, 1);

    // Reset mid-period: pending values are lost
    run_cycles(40, -1, 0, 0, 0, hr, hg, hb, hps);
    rst = 1'b1; en = 1'b0;
    step();
    chk("midrst_pwm_r", pwm_r, 0);
    chk("midrst_ps", period_start, 0);
    rst = 1'b0; en = 1'b1;
    step();
    chk("midrst_en_ps", period_start, 1);
    run_cycles(255, -1, 0, 0, 0, hr, hg, hb, hps);
    chk("midrst_r", hr, 0);
    chk("midrst_ps_cnt", hps, 1);

    // Prescale and inversion: PRESCALE=3, ACTIVE_LOW=1, B=5
    chk("inv_idle_pwm_b", pwm_b2, 1);
    update2 = 1'b1; r_in2 = 8'd0; g_in2 = 8'd0; b_in2 = 8'd5;
    step();
    update2 = 1'b0;
    en2 = 1'b1;
    step();
    chk("inv_en_ps", period_start2, 1);
    lr = 0; lg = 0; lb = 0; lps = 0;
    for (int i = 0; i < 765; i++) begin
      step();
      lr  += int'(!pwm_r2);
      lg  += int'(!pwm_g2);
      lb  += int'(!pwm_b2);
      lps += int'(period_start2);
    end
    chk("inv_b_low", lb, 15);
    chk("inv_r_low", lr, 0);
    chk("inv_g_low", lg, 0);
    chk("inv_ps_cnt", lps, 1);
    chk("inv_ps_end", period_start2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Converts the three 8-bit colour intensities from the RGB processor into three PWM waveforms for the physical RGB LED pins. Duty values are captured on an update strobe and applied only at PWM period boundaries, so an LED never sees a torn or glitched cycle. The block sits between the RGB processor's `r_out`/`g_out`/`b_out` registers and the board's LED drive pins.

## Interface
- `PRESCALE`, default 4: clk cycles per PWM tick. Legal range is 1 to 65535.
- `ACTIVE_LOW`, default 0: when 1, the PWM pins are inverted for common-anode LEDs.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run request. Sampled into the `run` register.
- `update`  in  1  while high, `r_in`/`g_in`/`b_in` load into the pending registers at the clock edge.
- `r_in`, `g_in`, `b_in`  in  8 each  requested duty values (0 = off, 255 = fully on).
- `pwm_r`, `pwm_g`, `pwm_b`  out  1 each  registered PWM outputs.
- `period_start`  out  1  one-cycle pulse on the first cycle of each PWM period.

## Operation
- **State registers**
  - `run`
  - `pre`, a prescaler of width clog2(PRESCALE), min 1
  - `cnt`, 8 bits
  - pending duties `pend_r/g/b`, 8 bits each
  - active duties `act_r/g/b`, 8 bits each
  - the three PWM output flops
- **Reset** (`rst`=1 at an edge): every register is cleared to 0, except the PWM flops, which go to the inactive level (= `ACTIVE_LOW`). `period_start` is 0. Reset overrides every other input in the same cycle.
- **Pending capture:** if `update`=1 at an edge, `pend_x <= x_in`. This works in every state, including while idle.
- **Idle** (`run`=0):
  - `pre` and `cnt` are held at 0.
  - `act_x <= pend_x` every cycle, so active tracks pending with one cycle of lag.
  - PWM outputs are inactive.
- **Running** (`run`=1):
  - A tick occurs when `pre == PRESCALE-1`. On a tick `pre <= 0`; otherwise `pre` increments.
  - On a tick, `cnt` increments. When `cnt == 254`, the tick wraps it to 0 instead. A period is therefore 255 ticks = 255·PRESCALE clk cycles.
  - On the wrap edge, `act_x <= pend_x`, using pend's value from before that edge. This is the only point where active changes while running.
- **Compare:** the next value of each PWM flop is `ACTIVE_LOW XOR (run AND cnt < act_x)`.
  - Duty 0 gives a constant inactive output.
  - Duty 255 gives a constant active output, because `cnt` never reaches 255.
  - Duty D is active for D·PRESCALE cycles per period.
- **`period_start`** is decoded from registers only: `run AND cnt==0 AND pre==0`. There is no combinational path from any input to any output.

## Timing
- **Output latency:** the PWM pins reflect the (`cnt`, `act`) state with one clk of delay.
- **Enable:**
  - `en`=1 sampled at edge k gives `run`=1 after edge k.
  - `period_start` is high in the cycle after edge k. `act` holds the pending value from before edge k−1 or later.
  - The first active PWM level appears after edge k+1.
- **Disable:**
  - `en`=0 sampled at edge k gives `run`=0 after edge k.
  - The PWM pins go inactive after edge k+1.
  - `cnt` and `pre` are 0 after edge k+1, which aborts the partial period. No `period_start` is generated.
- **Update mid-period:** the current period finishes with the old duty. The new duty takes effect from the next `period_start`.
- **Update on the wrap edge** (same edge as `cnt` 254→0): `act` loads the old pending value. The new value applies one period later.
- **Multiple updates in one period:** the last one wins.
- **Reset mid-period:** the state after the reset edge is identical to power-on reset. The pending values are lost.

## Test plan
- **Reset defaults:** assert `rst` with ACTIVE_LOW=0 → all PWM pins 0, `period_start` 0. Repeat with ACTIVE_LOW=1 → all pins 1.
- **Basic duty** (PRESCALE=1): load R=0, G=128, B=255, then `en`=1.
  - Each 255-cycle period counts R high 0, G high 128, B high 255 cycles.
  - `period_start` pulses exactly every 255 cycles.
- **Mid-period update** (PRESCALE=1):
  - Running with G=100, pulse `update` with G=20 at cnt=50.
  - The current period shows G high for 100 cycles.
  - The next period shows G high for 20 cycles, starting with the `period_start` pulse.
- **Update on the wrap edge:** pulse `update` with G=10 on the edge where cnt goes 254→0.
  - The following period still uses the old G.
  - The period after that shows G=10.
- **Enable toggle:**
  - Deassert `en` at cnt=30 → pins go inactive two edges later, with no `period_start`.
  - Load R=200 while idle, then reassert `en` → `period_start` fires one cycle after the sampling edge, and R is high for 200 cycles.
- **Prescale and inversion** (PRESCALE=3, ACTIVE_LOW=1, B=5):
  - Period = 765 cycles.
  - `pwm_b` is low for 15 cycles and high for 750 cycles per period.
